uart_tx_framer: RTL and testbench

Frame builder for the board's UART command link: accepts one 64-bit word per request and emits it as a byte stream, header 8'hEB, 8'h9C, then 8 payload bytes least-significant first, with an optional 8-bit additive checksum byte. Sits between the control logic and the UART byte serializer. Mirrors the frame format the link's receive-side deframer expects, so the output can be looped straight into that deframer for self-test.

---
 rtl/uart_tx_framer_if.sv | 21 ++
 rtl/uart_tx_framer.sv | 114 +++++++++++
 tb/tb_uart_tx_framer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framer_if.sv
// Handshake and byte-stream signals between the control logic, the UART TX framer and the
// byte serializer.
interface uart_tx_framer_if;
  logic [63:0] send_data;
  logic        send_valid;
  logic        send_ready;
  logic        byte_ready;
  logic [7:0]  frame_data_out;
  logic        frame_data_ena;
  logic        tx_done;

  modport master (
    output send_data, send_valid, byte_ready,
    input  send_ready, frame_data_out, frame_data_ena, tx_done
  );

  modport slave (
    input  send_data, send_valid, byte_ready,
    output send_ready, frame_data_out, frame_data_ena, tx_done
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART command-link frame builder: EB 9C header, 8 payload bytes LSB first, optional
// additive checksum byte. One registered strobe per byte, paced by byte_ready.
module uart_tx_framer #(
  parameter bit CHECKSUM_EN = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  uart_tx_framer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StData, StChk} state_e;

  state_e      state_q, state_d;
  logic [63:0] shift_q, shift_d;
  logic [7:0]  acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        load_q, load_d;
  logic        ena_q, ena_d;
  logic [7:0]  out_q, out_d;
  logic        done_q, done_d;

  logic       idle;
  logic       accept;
  logic       issue;
  logic       advance;
  logic       last;
  logic [7:0] cur_byte;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      ena_q   <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      ena_q   <= ena_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // A state moves on at the edge after its strobe, so the state still names the byte that is
  // on the bus and send_ready only rises once the last strobe has gone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StHdr0;
      StHdr0: if (advance) state_d = StHdr1;
      StHdr1: if (advance) state_d = StData;
      StData: begin
        if (advance && cnt_q == 3'd7) state_d = CHECKSUM_EN ? StChk : StIdle;
      end
      StChk:  if (advance) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    idle   = (state_q == StIdle);
    accept = bus.send_valid && idle;
    case (state_q)
      StHdr0:  cur_byte = 8'hEB;
      StHdr1:  cur_byte = 8'h9C;
      StData:  cur_byte = shift_q[7:0];
      StChk:   cur_byte = acc_q;
      default: cur_byte = 8'h00;
    endcase
    // load_q gives the freshly captured word one settling cycle before the first byte.
    issue   = !idle && bus.byte_ready && !ena_q && !load_q;
    advance = !idle && ena_q;
    last    = advance && ((state_q == StData && cnt_q == 3'd7 && !CHECKSUM_EN) ||
                          state_q == StChk);

    bus.send_ready     = idle;
    bus.frame_data_ena = ena_q;
    bus.frame_data_out = out_q;
    bus.tx_done        = done_q;
  end

  // Datapath next-state
  always_comb begin
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    load_d  = accept;
    ena_d   = issue;
    out_d   = issue ? cur_byte : out_q;
    done_d  = last;
    if (accept) begin
      shift_d = bus.send_data;
      cnt_d   = 3'd0;
      acc_d   = 8'h00;
    end
    if (issue) begin
      acc_d = acc_q + cur_byte;
    end
    if (advance && state_q == StData) begin
      shift_d = shift_q >> 8;
      cnt_d   = cnt_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench: one framer without and one with the checksum byte, driven side by side.
module tb_uart_tx_framer;

  logic        clk;
  logic        rst_n;
  logic [63:0] send_data;
  logic        sv0;
  logic        sv1;
  logic        byte_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_b [0:10];

  uart_tx_framer_if if0 ();
  uart_tx_framer_if if1 ();

  assign if0.send_data  = send_data;
  assign if0.send_valid = sv0;
  assign if0.byte_ready = byte_ready;
  assign if1.send_data  = send_data;
  assign if1.send_valid = sv1;
  assign if1.byte_ready = byte_ready;

  uart_tx_framer #(.CHECKSUM_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  uart_tx_framer #(.CHECKSUM_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [63:0] d);
    logic [7:0] sum;
    exp_b[0] = 8'hEB;
    exp_b[1] = 8'h9C;
    sum = 8'hEB + 8'h9C;
    for (int i = 0; i < 8; i++) begin
      exp_b[2+i] = d[8*i +: 8];
      sum = sum + d[8*i +: 8];
    end
    exp_b[10] = sum;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy0"}, if0.send_ready, 1'b1);
    chk({tag, "_ena0"}, if0.frame_data_ena, 1'b0);
    chk({tag, "_out0"}, if0.frame_data_out, 8'h00);
    chk({tag, "_done0"}, if0.tx_done, 1'b0);
    chk({tag, "_rdy1"}, if1.send_ready, 1'b1);
    chk({tag, "_ena1"}, if1.frame_data_ena, 1'b0);
    chk({tag, "_out1"}, if1.frame_data_out, 8'h00);
    chk({tag, "_done1"}, if1.tx_done, 1'b0);
  endtask

  // Present a word for one edge; returns #1 after the accept edge with send_valid dropped.
  task automatic start(input logic [63:0] d, input bit a0, input bit a1);
    send_data = d;
    sv0 = a0;
    sv1 = a1;
    tick(1);
    if (a0) chk("accept_rdy0", if0.send_ready, 1'b0);
    if (a1) chk("accept_rdy1", if1.send_ready, 1'b0);
    sv0 = 1'b0;
    sv1 = 1'b0;
  endtask

  // Checks every cycle from now until tx_done: byte first_idx strobes 'lead' edges from now,
  // then one byte every two edges; tx_done and send_ready rise the edge after the last strobe.
  task automatic run_bytes(input int first_idx, input int lead, input bit on0, input bit on1);
    int done0;
    int done1;
    int last_j;
    done0  = lead + 2 * (9 - first_idx) + 1;
    done1  = lead + 2 * (10 - first_idx) + 1;
    last_j = on1 ? done1 : done0;
    for (int j = 1; j <= last_j; j++) begin
      int s;
      int idx;
      bit strobe;
      tick(1);
      s      = j - lead;
      strobe = (s >= 0) && (s % 2 == 0);
      idx    = first_idx + s / 2;
      if (on0) begin
        chk("ena0", if0.frame_data_ena, strobe && idx <= 9);
        if (strobe && idx <= 9) chk("byte0", if0.frame_data_out, exp_b[idx]);
        chk("done0", if0.tx_done, j == done0);
        chk("rdy0", if0.send_ready, j >= done0);
      end
      if (on1) begin
        chk("ena1", if1.frame_data_ena, strobe && idx <= 10);
        if (strobe && idx <= 10) chk("byte1", if1.frame_data_out, exp_b[idx]);
        chk("done1", if1.tx_done, j == done1);
        chk("rdy1", if1.send_ready, j >= done1);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    sv0        = 1'b1;
    sv1        = 1'b1;
    byte_ready = 1'b1;
    send_data  = 64'h1122334455667788;
    set_exp(send_data);

    // Reset held with send_valid high: idle, no strobes
    #2;
    chk_reset_vals("reset");
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_ena0", if0.frame_data_ena, 1'b0);
      chk("rst_ena1", if1.frame_data_ena, 1'b0);
      chk("rst_rdy0", if0.send_ready, 1'b1);
    end
    rst_n = 1'b1;
    tick(1);
    chk("first_edge_rdy0", if0.send_ready, 1'b0);
    chk("first_edge_rdy1", if1.send_ready, 1'b0);
    sv0 = 1'b0;
    sv1 = 1'b0;
    // Basic 10-byte and checksum 11-byte frames (checksum of this word is EB)
    run_bytes(0, 2, 1'b1, 1'b1);
    chk("basic_chk_byte", if1.frame_data_out, 8'hEB);

    // Backpressure after the third strobe, with ignored requests and data changes mid-frame
    set_exp(64'h1122334455667788);
    start(64'h1122334455667788, 1'b1, 1'b1);
    tick(6);
    chk("bp_ena0", if0.frame_data_ena, 1'b1);
    chk("bp_byte0", if0.frame_data_out, 8'h88);
    chk("bp_ena1", if1.frame_data_ena, 1'b1);
    byte_ready = 1'b0;
    for (int g = 1; g <= 50; g++) begin
      tick(1);
      if (g == 10) begin
        sv0 = 1'b1;
        sv1 = 1'b1;
        send_data = 64'hDEADBEEFCAFEF00D;
      end
      if (g == 14) begin
        sv0 = 1'b0;
        sv1 = 1'b0;
      end
      chk("gap_ena0", if0.frame_data_ena, 1'b0);
      chk("gap_ena1", if1.frame_data_ena, 1'b0);
      chk("gap_rdy0", if0.send_ready, 1'b0);
      chk("gap_out0", if0.frame_data_out, 8'h88);
    end
    byte_ready = 1'b1;
    run_bytes(3, 1, 1'b1, 1'b1);

    // Back-to-back on the plain framer: B is presented during A but accepted on A's tx_done cycle
    send_data = 64'hA1A2A3A4A5A6A7A8;
    sv0 = 1'b1;
    sv1 = 1'b0;
    tick(1);
    chk("b2b_acc_a", if0.send_ready, 1'b0);
    send_data = 64'hB1B2B3B4B5B6B7B8;
    set_exp(64'hA1A2A3A4A5A6A7A8);
    run_bytes(0, 2, 1'b1, 1'b0);
    tick(1);
    chk("b2b_acc_b", if0.send_ready, 1'b0);
    chk("b2b_done_pulse", if0.tx_done, 1'b0);
    sv0 = 1'b0;
    set_exp(64'hB1B2B3B4B5B6B7B8);
    run_bytes(0, 2, 1'b1, 1'b0);

    // Random words, with an asynchronous reset partway through one frame
    for (int n = 0; n < 100; n++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      set_exp(d);
      start(d, 1'b1, 1'b1);
      if (n == 50) begin
        tick(6);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick(2);
        chk("midrst_ena0", if0.frame_data_ena, 1'b0);
        chk("midrst_done1", if1.tx_done, 1'b0);
        rst_n = 1'b1;
      end else begin
        run_bytes(0, 2, 1'b1, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
